// File: rtl/ram_dist_pkg.sv
// Shared encodings for the distributed dual-port RAM: clear-sequencer states
// and read-during-write mode selectors.
package ram_dist_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_HOLD = 2'd1,
    CLEAR      = 2'd2
  } clr_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_dist_clr_seq.sv
// Clear sequencer: parks at address 0 while reset is held, then walks every
// address once with a write strobe. The busy flag is registered.
module ram_dist_clr_seq
  import ram_dist_pkg::*;
#(
  parameter int  DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              busy_o
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  clr_state_e        state_q = IDLE;
  logic [ADDR_W:0]   cnt_q   = '0;
  logic [ADDR_W:0]   cnt_d;
  logic              busy_q  = 1'b0;

  assign cnt_d = cnt_q + CNT_ONE;

  // The edge that releases reset already writes word 0, so the fill ends
  // DEPTH edges after the last reset edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_HOLD;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        CLEAR_HOLD, CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= CLEAR;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we_o   = (state_q != IDLE) && !rst_i;
  assign clr_addr_o = cnt_q[ADDR_W-1:0];
  assign busy_o     = busy_q;

endmodule

// File: rtl/ram_dist_dp.sv
// WIDTH x DEPTH dual-port LUT RAM: one read/write port, one read-only port,
// optional output registers with selectable read-during-write, hardware clear.
module ram_dist_dp
  import ram_dist_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 64,
  parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}},
  parameter int               OREG     = 0,
  parameter int               RDW_MODE = RDW_READ_FIRST,
  localparam int              ADDR_W   = $clog2(DEPTH)
) (
  input  logic              WCLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] DPRA,
  output logic [WIDTH-1:0]  SPO,
  output logic [WIDTH-1:0]  DPO,
  output logic              BUSY
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              usr_we;

  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  ram_dist_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk_i      (WCLK),
    .rst_i      (RST),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );

  assign usr_we = WE && !RST && !busy;
  assign BUSY   = busy;

  always_ff @(posedge WCLK) begin
    if (clr_we) begin
      mem_q[clr_addr] <= INIT_VAL;
    end else if (usr_we) begin
      mem_q[A] <= D;
    end
  end

  generate
    if (OREG == 0) begin : g_async
      assign SPO = mem_q[A];
      assign DPO = mem_q[DPRA];
    end else begin : g_oreg
      logic [WIDTH-1:0] spo_q = '0;
      logic [WIDTH-1:0] dpo_q = '0;
      logic [WIDTH-1:0] spo_d;
      logic [WIDTH-1:0] dpo_d;

      // Non-blocking array update means a plain read already yields the old word.
      always_comb begin
        spo_d = mem_q[A];
        dpo_d = mem_q[DPRA];
        if ((RDW_MODE == RDW_WRITE_FIRST) && usr_we) begin
          spo_d = D;
          if (DPRA == A) begin
            dpo_d = D;
          end
        end
      end

      always_ff @(posedge WCLK) begin
        if (RST || busy) begin
          spo_q <= '0;
          dpo_q <= '0;
        end else begin
          spo_q <= spo_d;
          dpo_q <= dpo_d;
        end
      end

      assign SPO = spo_q;
      assign DPO = dpo_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dist_dp.sv
// Bench for ram_dist_dp: three instances (async, registered read-first,
// registered write-first) share one stimulus stream.
module tb_ram_dist_dp;

  logic       WCLK = 1'b0;
  logic       RST;
  logic       WE;
  logic [5:0] A;
  logic [5:0] DPRA;
  logic [7:0] D;

  logic [7:0] spo0, dpo0, spo1, dpo1, spo2, dpo2;
  logic       busy0, busy1, busy2;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl [64];

  localparam logic [3:0] S_SPO0  = 4'd0;
  localparam logic [3:0] S_DPO0  = 4'd1;
  localparam logic [3:0] S_SPO1  = 4'd2;
  localparam logic [3:0] S_DPO1  = 4'd3;
  localparam logic [3:0] S_SPO2  = 4'd4;
  localparam logic [3:0] S_DPO2  = 4'd5;
  localparam logic [3:0] S_BUSY0 = 4'd6;
  localparam logic [3:0] S_BUSY1 = 4'd7;
  localparam logic [3:0] S_BUSY2 = 4'd8;

  typedef struct packed {
    logic [95:0] tag;
    logic [3:0]  src;
    logic [7:0]  exp;
  } exp_t;

  typedef struct packed {
    logic       we;
    logic [5:0] a;
    logic [7:0] d;
    logic [5:0] dpra;
    logic [7:0] spo;
    logic [7:0] dpo;
  } vec_t;

  exp_t sb[$];
  vec_t vt [7];

  always #5 WCLK = ~WCLK;

  ram_dist_dp #(.WIDTH(8), .DEPTH(64), .INIT_VAL(8'hA5), .OREG(0), .RDW_MODE(0)) u_async (
    .WCLK(WCLK), .RST(RST), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo0), .DPO(dpo0), .BUSY(busy0)
  );

  ram_dist_dp #(.WIDTH(8), .DEPTH(64), .INIT_VAL(8'hA5), .OREG(1), .RDW_MODE(0)) u_rf (
    .WCLK(WCLK), .RST(RST), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo1), .DPO(dpo1), .BUSY(busy1)
  );

  ram_dist_dp #(.WIDTH(8), .DEPTH(64), .INIT_VAL(8'hA5), .OREG(1), .RDW_MODE(1)) u_wf (
    .WCLK(WCLK), .RST(RST), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo2), .DPO(dpo2), .BUSY(busy2)
  );

  function automatic logic [7:0] obs(input logic [3:0] s);
    case (s)
      S_SPO0:  return spo0;
      S_DPO0:  return dpo0;
      S_SPO1:  return spo1;
      S_DPO1:  return dpo1;
      S_SPO2:  return spo2;
      S_DPO2:  return dpo2;
      S_BUSY0: return {7'b0, busy0};
      S_BUSY1: return {7'b0, busy1};
      S_BUSY2: return {7'b0, busy2};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(input logic [95:0] tag, input logic [3:0] src, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.src);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %0s src=%0d at %0t: got %h want %h", e.tag, e.src, $time, got, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge WCLK);
    #2;
  endtask

  task automatic check_all_init(input logic [95:0] tag);
    for (int i = 0; i < 64; i++) begin
      A    = 6'(i);
      DPRA = 6'(63 - i);
      #1;
      push(tag, S_SPO0, 8'hA5);
      push(tag, S_DPO0, 8'hA5);
      drain();
    end
  endtask

  task automatic fill_ff();
    WE = 1'b1;
    D  = 8'hFF;
    for (int i = 0; i < 64; i++) begin
      A = 6'(i);
      tick();
    end
    WE = 1'b0;
    A  = 6'd17;
    DPRA = 6'd50;
    #1;
    push("fill_spo", S_SPO0, 8'hFF);
    push("fill_dpo", S_DPO0, 8'hFF);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old_a;
    logic [7:0] old_r;

    // {we, a, d, dpra, spo after edge, dpo after edge} for the async instance
    vt[0] = '{1'b1, 6'd5,  8'h3C, 6'd5,  8'h3C, 8'h3C};
    vt[1] = '{1'b1, 6'd63, 8'hC3, 6'd0,  8'hC3, 8'hA5};
    vt[2] = '{1'b0, 6'd0,  8'h00, 6'd63, 8'hA5, 8'hC3};
    vt[3] = '{1'b1, 6'd0,  8'h5A, 6'd63, 8'h5A, 8'hC3};
    vt[4] = '{1'b0, 6'd63, 8'h99, 6'd5,  8'hC3, 8'h3C};
    vt[5] = '{1'b1, 6'd32, 8'h81, 6'd31, 8'h81, 8'hA5};
    vt[6] = '{1'b0, 6'd31, 8'h00, 6'd32, 8'hA5, 8'h81};

    RST = 1'b0; WE = 1'b0; A = '0; D = '0; DPRA = '0;
    for (int i = 0; i < 64; i++) mdl[i] = 8'hA5;

    #1;
    push("pwr_busy", S_BUSY0, 8'd0);
    push("pwr_busy", S_BUSY1, 8'd0);
    push("pwr_busy", S_BUSY2, 8'd0);
    push("pwr_rspo", S_SPO1, 8'h00);
    push("pwr_rdpo", S_DPO1, 8'h00);
    push("pwr_rspo", S_SPO2, 8'h00);
    push("pwr_rdpo", S_DPO2, 8'h00);
    drain();
    check_all_init("pwr_read");

    @(posedge WCLK);
    #2;

    for (int i = 0; i < 7; i++) begin
      WE = vt[i].we; A = vt[i].a; D = vt[i].d; DPRA = vt[i].dpra;
      old_a = mdl[vt[i].a];
      old_r = mdl[vt[i].dpra];
      push("vec_spo", S_SPO0, vt[i].spo);
      push("vec_dpo", S_DPO0, vt[i].dpo);
      push("vec_rf_spo", S_SPO1, old_a);
      push("vec_rf_dpo", S_DPO1, old_r);
      push("vec_wf_spo", S_SPO2, vt[i].we ? vt[i].d : old_a);
      push("vec_wf_dpo", S_DPO2, (vt[i].we && vt[i].a == vt[i].dpra) ? vt[i].d : old_r);
      tick();
      drain();
      if (vt[i].we) mdl[vt[i].a] = vt[i].d;
    end

    // Read-during-write on address 7 through both ports
    WE = 1'b1; A = 6'd7; DPRA = 6'd7; D = 8'h11;
    tick();
    D = 8'h22;
    push("rf_old_spo", S_SPO1, 8'h11);
    push("rf_old_dpo", S_DPO1, 8'h11);
    push("wf_new_spo", S_SPO2, 8'h22);
    push("wf_new_dpo", S_DPO2, 8'h22);
    push("as_new_spo", S_SPO0, 8'h22);
    tick();
    drain();
    WE = 1'b0;
    push("rf_next_spo", S_SPO1, 8'h22);
    push("rf_next_dpo", S_DPO1, 8'h22);
    tick();
    drain();
    WE = 1'b1; A = 6'd9; DPRA = 6'd7; D = 8'h44;
    push("wf_other_dpo", S_DPO2, 8'h22);
    push("wf_other_spo", S_SPO2, 8'h44);
    push("rf_other_spo", S_SPO1, 8'hA5);
    tick();
    drain();
    WE = 1'b0;

    // Full clear: reset held for three edges, WE pulses ignored while busy
    fill_ff();
    for (int e = 0; e <= 66; e++) begin
      RST  = (e < 3);
      WE   = (e % 2 == 0);
      A    = 6'($urandom_range(0, 63));
      DPRA = A;
      D    = 8'h00;
      push("clr_busy", S_BUSY0, (e < 66) ? 8'd1 : 8'd0);
      push("clr_busy", S_BUSY1, (e < 66) ? 8'd1 : 8'd0);
      push("clr_busy", S_BUSY2, (e < 66) ? 8'd1 : 8'd0);
      push("clr_rspo", S_SPO1, 8'h00);
      push("clr_rdpo", S_DPO2, 8'h00);
      tick();
      drain();
    end
    RST = 1'b0; WE = 1'b0;
    check_all_init("clr_read");

    @(posedge WCLK);
    #2;
    A = 6'd12; DPRA = 6'd40;
    push("clr_reg_spo", S_SPO1, 8'hA5);
    push("clr_reg_dpo", S_DPO2, 8'hA5);
    tick();
    drain();

    // Reset pulse in the middle of the fill restarts the counter
    fill_ff();
    for (int e = 0; e <= 95; e++) begin
      RST  = (e == 0) || (e == 31);
      WE   = 1'b1;
      A    = 6'($urandom_range(0, 63));
      DPRA = A;
      D    = 8'h00;
      push("mid_busy", S_BUSY0, (e < 95) ? 8'd1 : 8'd0);
      push("mid_busy", S_BUSY2, (e < 95) ? 8'd1 : 8'd0);
      tick();
      drain();
    end
    RST = 1'b0; WE = 1'b0;
    check_all_init("mid_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
